// File: rtl/alu_sweep_if.sv
// ALU datapath bus: operands and opcode from the initiator, result and zero flag back from the ALU.
interface alu_sweep_if;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [3:0]  alu_ctrl;
  logic [31:0] dreg;
  logic        zero;

  modport master (output reg1, reg2, alu_ctrl, input dreg, zero);
  modport slave  (input reg1, reg2, alu_ctrl, output dreg, zero);
endinterface

// File: rtl/alu_sweep_driver.sv
// Steps an ALU through all 16 opcodes on a held operand pair, streaming each result
// and folding it into a rotate-xor signature plus a zero-flag count.
module alu_sweep_driver #(
  parameter int unsigned SETTLE = 1  // 1..15 cycles of opcode hold before sampling
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  alu_sweep_if.master alu,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [4:0]  zero_count,
  output logic        result_we,
  output logic [3:0]  result_idx,
  output logic [31:0] result_data
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  function automatic logic [31:0] sig_fold(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31]} ^ d;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] reg2_q, reg2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] sig_q, sig_d;
  logic [4:0]  zc_q, zc_d;
  logic        we_q, we_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    ctrl_d  = ctrl_q;
    sig_d   = sig_q;
    zc_d    = zc_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          reg1_d  = op_a;
          reg2_d  = op_b;
          ctrl_d  = 4'd0;
          sig_d   = 32'd0;
          zc_d    = 5'd0;
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        sig_d  = sig_fold(sig_q, alu.dreg);
        zc_d   = zc_q + 5'(alu.zero);
        we_d   = 1'b1;
        idx_d  = ctrl_q;
        data_d = alu.dreg;
        // Opcode 15 is left on the bus so the final sweep state stays observable.
        if (ctrl_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          ctrl_d  = ctrl_q + 4'd1;
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      reg1_q  <= 32'd0;
      reg2_q  <= 32'd0;
      ctrl_q  <= 4'd0;
      sig_q   <= 32'd0;
      zc_q    <= 5'd0;
      we_q    <= 1'b0;
      idx_q   <= 4'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      ctrl_q  <= ctrl_d;
      sig_q   <= sig_d;
      zc_q    <= zc_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign alu.reg1     = reg1_q;
  assign alu.reg2     = reg2_q;
  assign alu.alu_ctrl = ctrl_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign signature    = sig_q;
  assign zero_count   = zc_q;
  assign result_we    = we_q;
  assign result_idx   = idx_q;
  assign result_data  = data_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Scoreboard bench: two sweep drivers (SETTLE=1 and SETTLE=3) driven by shared stimulus against ALU models.
module tb_alu_sweep_driver;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [31:0] op_a, op_b;
  int          mode;
  int          cyc = 0;
  int          n_vec = 0, n_fail = 0;

  alu_sweep_if if0();
  alu_sweep_if if1();

  logic        busy0, done0, we0, busy1, done1, we1;
  logic [31:0] sig0, data0, sig1, data1;
  logic [4:0]  zc0, zc1;
  logic [3:0]  idx0, idx1;

  alu_sweep_driver #(.SETTLE(1)) dut0 (
    .clk(clk), .reset(rst), .start(start0), .op_a(op_a), .op_b(op_b), .alu(if0),
    .busy(busy0), .done(done0), .signature(sig0), .zero_count(zc0),
    .result_we(we0), .result_idx(idx0), .result_data(data0));

  alu_sweep_driver #(.SETTLE(3)) dut1 (
    .clk(clk), .reset(rst), .start(start1), .op_a(op_a), .op_b(op_b), .alu(if1),
    .busy(busy1), .done(done1), .signature(sig1), .zero_count(zc1),
    .result_we(we1), .result_idx(idx1), .result_data(data1));

  // ALU behaviour: {zero, dreg}
  function automatic logic [32:0] alu_f(input int m, input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] r;
    case (m)
      0: begin r = {28'b0, c}; return {c == 4'd0, r}; end
      1: return {1'b1, 32'h0};
      2: return {1'b0, 32'h8000_0000};
      default: begin
        case (c)
          4'd0:  r = a + b;
          4'd1:  r = a - b;
          4'd2:  r = a & b;
          4'd3:  r = a | b;
          4'd4:  r = a ^ b;
          4'd5:  r = ~(a | b);
          4'd6:  r = a << b[4:0];
          4'd7:  r = a >> b[4:0];
          4'd8:  r = $signed(a) >>> b[4:0];
          4'd9:  r = {31'b0, $signed(a) < $signed(b)};
          4'd10: r = {31'b0, a < b};
          4'd11: r = a;
          4'd12: r = b;
          4'd13: r = 32'h0;
          4'd14: r = {a[15:0], b[15:0]};
          default: r = ~a;
        endcase
        return {r == 32'h0, r};
      end
    endcase
  endfunction

  assign {if0.zero, if0.dreg} = alu_f(mode, if0.reg1, if0.reg2, if0.alu_ctrl);
  assign {if1.zero, if1.dreg} = alu_f(mode, if1.reg1, if1.reg2, if1.alu_ctrl);

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [3:0] idx; logic [31:0] data; int at;} res_t;
  typedef struct {logic [31:0] sig; logic [4:0] zc; int at; logic [31:0] a; logic [31:0] b;} sum_t;
  res_t res_q[2][$];
  sum_t sum_q[2][$];
  bit   busy_chk[2];

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input int d);
    n_vec++;
    n_fail++;
    $display("FAIL %s dut%0d @cyc %0d: got event, expected none", name, d, cyc);
  endtask

  // Reference: results in opcode order, one per SETTLE+1 cycles, signature by rotate-xor.
  task automatic expect_sweep(input int d, input int start_cyc);
    int          settle = (d == 0) ? 1 : 3;
    logic [31:0] s = 32'h0;
    int          z = 0;
    logic [32:0] r;
    sum_t        e;
    for (int i = 0; i < 16; i++) begin
      r = alu_f(mode, op_a, op_b, 4'(i));
      res_q[d].push_back('{idx: 4'(i), data: r[31:0], at: start_cyc + (i + 1) * (settle + 1)});
      s = ((s << 1) | (s >> 31)) ^ r[31:0];
      z += int'(r[32]);
    end
    case (mode)
      0: begin s = 32'h0000_08F7; z = 1; end
      1: begin s = 32'h0000_0000; z = 16; end
      2: begin s = 32'h8000_7FFF; z = 0; end
      default: ;
    endcase
    e.sig = s; e.zc = 5'(z); e.at = start_cyc + 16 * (settle + 1); e.a = op_a; e.b = op_b;
    sum_q[d].push_back(e);
  endtask

  task automatic mon(input int d, input logic busy, input logic done, input logic we,
                     input logic [3:0] idx, input logic [31:0] data, input logic [31:0] sig,
                     input logic [4:0] zc, input logic [31:0] r1, input logic [31:0] r2);
    res_t r;
    sum_t s;
    if (busy_chk[d]) begin
      chk("busy_after_done", d, 64'(busy), 64'(0));
      busy_chk[d] = 1'b0;
    end
    if (busy && sum_q[d].size() > 0) begin
      chk("reg1_hold", d, 64'(r1), 64'(sum_q[d][0].a));
      chk("reg2_hold", d, 64'(r2), 64'(sum_q[d][0].b));
    end
    if (we) begin
      if (res_q[d].size() == 0) fail_msg("unexpected_result_we", d);
      else begin
        r = res_q[d].pop_front();
        chk("result_idx", d, 64'(idx), 64'(r.idx));
        chk("result_data", d, 64'(data), 64'(r.data));
        chk("result_cycle", d, 64'(cyc), 64'(r.at));
      end
    end
    if (done) begin
      if (sum_q[d].size() == 0) fail_msg("unexpected_done", d);
      else begin
        s = sum_q[d].pop_front();
        chk("signature", d, 64'(sig), 64'(s.sig));
        chk("zero_count", d, 64'(zc), 64'(s.zc));
        chk("done_cycle", d, 64'(cyc), 64'(s.at));
        busy_chk[d] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, busy0, done0, we0, idx0, data0, sig0, zc0, if0.reg1, if0.reg2);
    mon(1, busy1, done1, we1, idx1, data1, sig1, zc1, if1.reg1, if1.reg2);
  end

  task automatic check_zero(input int d, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [3:0] ctrl, input logic busy, input logic done,
                            input logic [31:0] sig, input logic [4:0] zc, input logic we,
                            input logic [3:0] idx, input logic [31:0] data);
    chk("rst_reg1", d, 64'(r1), 64'(0));
    chk("rst_reg2", d, 64'(r2), 64'(0));
    chk("rst_alu_ctrl", d, 64'(ctrl), 64'(0));
    chk("rst_busy", d, 64'(busy), 64'(0));
    chk("rst_done", d, 64'(done), 64'(0));
    chk("rst_signature", d, 64'(sig), 64'(0));
    chk("rst_zero_count", d, 64'(zc), 64'(0));
    chk("rst_result_we", d, 64'(we), 64'(0));
    chk("rst_result_idx", d, 64'(idx), 64'(0));
    chk("rst_result_data", d, 64'(data), 64'(0));
  endtask

  task automatic check_zero_both();
    check_zero(0, if0.reg1, if0.reg2, if0.alu_ctrl, busy0, done0, sig0, zc0, we0, idx0, data0);
    check_zero(1, if1.reg1, if1.reg2, if1.alu_ctrl, busy1, done1, sig1, zc1, we1, idx1, data1);
  endtask

  task automatic flush();
    res_q[0].delete(); res_q[1].delete();
    sum_q[0].delete(); sum_q[1].delete();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((sum_q[0].size() > 0 || sum_q[1].size() > 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (sum_q[0].size() > 0 || sum_q[1].size() > 0) begin
      n_vec++; n_fail++;
      $display("FAIL sweep_timeout: got no done within %0d cycles, expected done", budget);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      flush();
    end
  endtask

  // Called just after a clock edge with both drivers idle.
  task automatic sweep(input int m, input logic [31:0] a, input logic [31:0] b, input bit poke);
    mode = m; op_a = a; op_b = b;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    expect_sweep(0, cyc);
    expect_sweep(1, cyc);
    start0 = 1'b0; start1 = 1'b0;
    if (poke) begin
      for (int i = 0; i < 24; i++) begin
        @(posedge clk); #1;
        start0 = 1'($urandom_range(0, 1));
        start1 = 1'($urandom_range(0, 1));
        op_a = $urandom; op_b = $urandom;
      end
      start0 = 1'b0; start1 = 1'b0;
    end
    wait_idle(300);
  endtask

  initial begin
    int k;
    int n0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_both();
    rst = 1'b0;
    @(posedge clk); #1;

    sweep(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    sweep(1, $urandom, $urandom, 1'b0);
    sweep(2, $urandom, $urandom, 1'b0);
    sweep(0, 32'hF000_0000, 32'h0000_FEDC, 1'b1);
    for (int i = 0; i < 5; i++) sweep(3, $urandom, $urandom, 1'b1);
    sweep(int'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);

    // Start held high across DONE on the SETTLE=1 driver restarts it two edges later.
    mode = 0; op_a = $urandom; op_b = $urandom;
    start0 = 1'b1;
    @(posedge clk); #1;
    n0 = cyc;
    expect_sweep(0, n0);
    expect_sweep(0, n0 + 34);
    repeat (40) @(posedge clk);
    #1;
    start0 = 1'b0;
    wait_idle(200);

    // Reset in the middle of a sweep.
    mode = 0; op_a = $urandom; op_b = $urandom;
    start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    expect_sweep(0, cyc);
    expect_sweep(1, cyc);
    start0 = 1'b0; start1 = 1'b0;
    k = 0;
    while (if0.alu_ctrl != 4'd7 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_ctrl7", 0, 64'(if0.alu_ctrl), 64'(7));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush();
    check_zero_both();
    repeat (80) @(posedge clk);
    #1;
    sweep(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sweep_driver.md
# alu_sweep_driver

Sequential initiator for the ALU datapath interface. On `start`, it holds a fixed operand pair on `reg1`/`reg2` and steps `alu_ctrl` through all 16 opcodes. For each opcode it waits a programmable settle time, samples `dreg`/`zero`, streams each result out, and folds it into a 32-bit signature and a zero-flag count. It sits between the ALU and the self-test/debug logic, and drives the ALU from the requesting side.

## Interface
- `SETTLE`, default 1: cycles `alu_ctrl` is held before sampling; legal range 1..15.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: sweep request, sampled in IDLE only.
- `op_a` in 32: operand A, captured on accepted start.
- `op_b` in 32: operand B, captured on accepted start.
- `reg1` out 32: ALU operand A.
- `reg2` out 32: ALU operand B.
- `alu_ctrl` out 4: ALU opcode.
- `dreg` in 32: ALU result.
- `zero` in 1: ALU zero flag.
- `busy` out 1: high from accepted start until the DONE cycle, inclusive.
- `done` out 1: one-cycle completion pulse.
- `signature` out 32: running result signature.
- `zero_count` out 5: number of samples with `zero`=1, range 0..16.
- `result_we` out 1: one-cycle strobe per sampled opcode.
- `result_idx` out 4: opcode of the current `result_data`.
- `result_data` out 32: sampled `dreg`.

## Operation
- **States:** IDLE, WAIT, SAMPLE, DONE.
- **IDLE:**
  - `busy`=0.
  - When `start`=1: `reg1`<=`op_a`, `reg2`<=`op_b`, `alu_ctrl`<=0, `signature`<=0, `zero_count`<=0, settle counter<=0, then go to WAIT.
- **WAIT:**
  - Settle counter increments each cycle.
  - After exactly SETTLE cycles in WAIT, go to SAMPLE.
- **SAMPLE:** one cycle. At the clock edge ending it:
  - `signature`<={`signature`[30:0],`signature`[31]} ^ `dreg`.
  - `zero_count`<=`zero_count`+`zero`.
  - `result_we`<=1, `result_idx`<=`alu_ctrl`, `result_data`<=`dreg`.
  - If `alu_ctrl`==15, go to DONE and leave `alu_ctrl` at 15.
  - Otherwise `alu_ctrl`<=`alu_ctrl`+1, settle counter<=0, and go to WAIT.
- **DONE:** `done`=1 for this cycle only, then go to IDLE.
- **Holding rules:**
  - `reg1`/`reg2` stay constant for the whole sweep.
  - `signature`, `zero_count` and `alu_ctrl` hold their final values in IDLE until the next accepted start.
- **Start handling:** `start` is ignored in WAIT, SAMPLE and DONE. A `start` held high in IDLE after DONE begins a new sweep.
- **Arithmetic:** the signature rotation wraps bit 31 into bit 0. `zero_count` cannot overflow, since its maximum is 16.

## Timing
- **Reset values:**
  - All outputs are 0: `reg1`, `reg2`, `alu_ctrl`, `busy`, `done`, `signature`, `zero_count`, `result_we`, `result_idx`, `result_data`.
  - State resets to IDLE.
- **Reset mid-sweep:** reset takes priority over every transition. The next edge returns all outputs to reset values with no `done` pulse.
- **Result strobe:** `result_we` and its data are registered. They appear the cycle after SAMPLE and last exactly one cycle.
- **Per-opcode period:** SETTLE+1 cycles.
- **Latency:** with start accepted at edge 0, `done` is high in the cycle after edge 16·(SETTLE+1). Example: edge 32 for SETTLE=1.
- **Last opcode:** the last `result_we` pulse (idx 15) coincides with the `done` cycle.
- **Busy:** `busy` drops in the cycle after `done`.
- **ALU requirement:** the ALU must be combinational, or settle within SETTLE cycles of an `alu_ctrl` change.

## Test plan
- **Stepped ALU:** ALU model `dreg`={28'b0,`alu_ctrl`}, `zero`=(`alu_ctrl`==0), SETTLE=1 -> 16 `result_we` pulses with idx 0..15 and data 0..15 in order; final `signature`=0x000008F7; `zero_count`=1; `done` 32 cycles after the start edge.
- **All-zero ALU:** `dreg`=0, `zero`=1 -> `signature`=0x00000000, `zero_count`=16.
- **Rotation wrap:** `dreg`=0x80000000 constant, `zero`=0 -> `signature`=0x80007FFF, `zero_count`=0.
- **Settle timing and operand hold:** SETTLE=3, `op_a`=0xF0000000, `op_b`=0x0000FEDC -> each `alu_ctrl` value held 4 cycles; `done` at cycle 64; `reg1`/`reg2` constant throughout; `start` pulses during the sweep change nothing.
- **Reset mid-sweep:** assert `reset` while `alu_ctrl`=7 -> next cycle all outputs are 0 and state is IDLE, with no `done` pulse. A subsequent start reproduces the stepped-ALU result exactly.
